// File: rtl/hpdcache_lockarb.sv
// N-way request arbiter with grant locking across back-pressure and a
// fixed-priority or round-robin policy; the aging guard is built with HPDCACHE_LOCKARB_AGING_EN.

`ifdef HPDCACHE_LOCKARB_AGING_EN
// Per-requester wait counter; flags the requester urgent once saturated.
module hpdcache_lockarb_age #(
    parameter int AGE_MAX = 15,
    parameter int AW      = $clog2(AGE_MAX + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic xfer_i,
    output logic urgent_o
);
    logic [AW-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (!req_i || xfer_i)
            age_d = '0;
        else if (age_q != AW'(AGE_MAX))
            age_d = age_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) age_q <= '0;
        else       age_q <= age_d;
    end

    assign urgent_o = (age_q == AW'(AGE_MAX));
endmodule
`endif

module hpdcache_lockarb #(
    parameter int N       = 4,
    parameter int RR      = 0,
    parameter int AGE_MAX = 15,
    parameter int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          ready_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          valid_o
);
    if (N < 1)       begin : g_bad_n   $error("N must be >= 1");       end
    if (AGE_MAX < 1) begin : g_bad_age $error("AGE_MAX must be >= 1"); end

    logic [IW-1:0] ptr_q, ptr_d, lidx_q, lidx_d;
    logic          lock_q, lock_d;
    logic [N-1:0]  urgent;
    logic [IW-1:0] idx, j;
    logic          found, xfer;

`ifdef HPDCACHE_LOCKARB_AGING_EN
    for (genvar i = 0; i < N; i++) begin : g_age
        hpdcache_lockarb_age #(.AGE_MAX(AGE_MAX)) u_age (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .req_i    (req_i[i]),
            .xfer_i   (xfer & gnt_o[i]),
            .urgent_o (urgent[i])
        );
    end
`else
    assign urgent = '0;
`endif

    // Selection stages: lock, then urgent, then policy; reset masks everything.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        if (lock_q && req_i[lidx_q]) begin
            found = 1'b1;
            idx   = lidx_q;
        end
        for (int i = 0; i < N; i++) begin
            if (!found && urgent[i] && req_i[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        if (RR == 0) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req_i[i]) begin
                    found = 1'b1;
                    idx   = IW'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                j = IW'((int'(ptr_q) + k) % N);
                if (!found && req_i[j]) begin
                    found = 1'b1;
                    idx   = j;
                end
            end
        end
        if (rst_i || !found) begin
            found = 1'b0;
            idx   = '0;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (found) gnt_o[idx] = 1'b1;
    end

    assign gnt_idx_o = idx;
    assign valid_o   = found;
    assign xfer      = found & ready_i;

    always_comb begin
        ptr_d  = ptr_q;
        lock_d = 1'b0;
        lidx_d = lidx_q;
        if (found && !ready_i) begin
            lock_d = 1'b1;
            lidx_d = idx;
        end
        if (xfer && RR != 0)
            ptr_d = IW'((int'(idx) + 1) % N);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
            lidx_q <= lidx_d;
        end
    end
endmodule

// File: tb/tb_hpdcache_lockarb.sv
// Two arbiters (fixed priority and round-robin) on shared inputs, compared
// every cycle against a behavioural model of the arbitration rules.
module tb_hpdcache_lockarb;
    localparam int N       = 4;
    localparam int AGE_MAX = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        req = '0;
    logic                rdy = 1'b0;
    logic [1:0][N-1:0]   gnt;
    logic [1:0][1:0]     idx;
    logic [1:0]          vld;

    int n_cmp = 0;
    int n_err = 0;

    int m_lock [2];
    int m_lidx [2];
    int m_ptr  [2];
    int m_age  [2][N];
    int gsel   [2];

    hpdcache_lockarb #(.N(N), .RR(0), .AGE_MAX(AGE_MAX)) u_fp (
        .clk_i(clk), .rst_i(rst), .req_i(req), .ready_i(rdy),
        .gnt_o(gnt[0]), .gnt_idx_o(idx[0]), .valid_o(vld[0])
    );
    hpdcache_lockarb #(.N(N), .RR(1), .AGE_MAX(AGE_MAX)) u_rr (
        .clk_i(clk), .rst_i(rst), .req_i(req), .ready_i(rdy),
        .gnt_o(gnt[1]), .gnt_idx_o(idx[1]), .valid_o(vld[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_lock[p] = 0;
            m_lidx[p] = 0;
            m_ptr[p]  = 0;
            for (int i = 0; i < N; i++) m_age[p][i] = 0;
        end
    endtask

    // Returns the requester index the rules select, or -1 for no grant.
    function automatic int pick(input int p, input logic [N-1:0] r);
        int order[$];
        if (rst) return -1;
        if (m_lock[p] != 0 && r[m_lidx[p]]) return m_lidx[p];
`ifdef HPDCACHE_LOCKARB_AGING_EN
        for (int i = 0; i < N; i++)
            if (r[i] && m_age[p][i] == AGE_MAX) return i;
`endif
        for (int k = 0; k < N; k++) order.push_back(p == 0 ? k : (m_ptr[p] + k) % N);
        foreach (order[k]) if (r[order[k]]) return order[k];
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic rd);
        logic [N-1:0] eg;
        req = r;
        rdy = rd;
        #1;
        for (int p = 0; p < 2; p++) begin
            gsel[p] = pick(p, r);
            eg = '0;
            if (gsel[p] >= 0) eg[gsel[p]] = 1'b1;
            chk(p == 0 ? "fp_gnt" : "rr_gnt", 32'(gnt[p]), 32'(eg));
            chk(p == 0 ? "fp_idx" : "rr_idx", 32'(idx[p]), gsel[p] < 0 ? 0 : gsel[p]);
            chk(p == 0 ? "fp_vld" : "rr_vld", 32'(vld[p]), 32'(gsel[p] >= 0));
            chk("inv_onehot0", 32'($onehot0(gnt[p])), 1);
            chk("inv_subset", 32'((gnt[p] & ~r) == '0), 1);
            chk("inv_conserve", 32'(rst || r == '0 || vld[p]), 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            for (int p = 0; p < 2; p++) begin
                if (gsel[p] < 0) m_lock[p] = 0;
                else if (rdy) begin
                    m_lock[p] = 0;
                    if (p == 1) m_ptr[p] = (gsel[p] + 1) % N;
                end else begin
                    m_lock[p] = 1;
                    m_lidx[p] = gsel[p];
                end
`ifdef HPDCACHE_LOCKARB_AGING_EN
                for (int i = 0; i < N; i++) begin
                    if (!req[i] || (gsel[p] == i && rdy)) m_age[p][i] = 0;
                    else if (m_age[p][i] < AGE_MAX) m_age[p][i]++;
                end
`endif
            end
        end
        #1;
    endtask

    initial begin
        logic [N-1:0] r;
        model_reset();
        // Reset state: outputs held at zero even with requests present.
        drive(4'b1111, 1'b1);
        tick();
        rst = 1'b0;

        // Round-robin rotation.
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, 1'b1);
            chk("rr_rotation", 32'(idx[1]), k % 4);
            tick();
        end

        // Lock under stall: higher priority arrival must not steal the grant.
        drive(4'b0100, 1'b0); tick();
        drive(4'b0101, 1'b0); chk("lock_hold", 32'(gnt[0]), 32'h4); tick();
        drive(4'b0101, 1'b0); chk("lock_hold2", 32'(gnt[0]), 32'h4); tick();
        drive(4'b0101, 1'b1); chk("lock_xfer", 32'(gnt[0]), 32'h4); tick();
        drive(4'b0101, 1'b1); chk("after_xfer", 32'(gnt[0]), 32'h1); tick();

        // Lock release on drop.
        drive(4'b1000, 1'b0); tick();
        drive(4'b0010, 1'b0); chk("drop_release", 32'(gnt[0]), 32'h2); tick();
        drive(4'b1010, 1'b1); tick();

        // Reset mid-stall with the round-robin pointer at 3.
        drive(4'b0100, 1'b1); tick();
        drive(4'b0100, 1'b0); tick();
        rst = 1'b1;
        drive(4'b0100, 1'b0); chk("rst_gnt", 32'(gnt[1]), 0);
        tick();
        rst = 1'b0;
        drive(4'b1111, 1'b1); chk("rst_rr_restart", 32'(idx[1]), 0); tick();

        // Two steady requesters; the aging guard (when built) interleaves them.
        for (int k = 0; k < 10; k++) begin
            drive(4'b1001, 1'b1);
            tick();
        end

        // Random sweep with sticky requests so locks and stalls occur.
        r = '0;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(3, 0) != 0) r = N'($urandom);
            rst = ($urandom_range(999, 0) == 0);
            drive(r, $urandom_range(2, 0) != 0);
            tick();
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
